uart_echo_buffer: RTL and testbench
===================================

# uart_echo_buffer

Parametrised receive-to-transmit bridge between the `UART` block's receive and transmit sides. It replaces the single-register echo loop with a DEPTH-entry FIFO, a per-byte transform selected at run time, and a selectable overflow policy. It exposes fill level and a sticky overflow flag. It sits in the board-level UART test top and, later, in front of the RSA command parser.

## Interface
- DATA_W, 8, byte width; must match UART data width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- OVF_DROP, 0, overflow policy: 0 = backpressure (leave byte unacknowledged in the UART), 1 = acknowledge and discard.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- rx_readable  in  1  UART has a byte; held high until acknowledged.
- rx_data  in  DATA_W  received byte; valid while rx_readable=1.
- rx_used_tick  out  1  one-cycle acknowledge to the UART.
- tx_busy  in  1  UART transmitter active.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  DATA_W  byte to transmit; registered, stable from tx_start until tx_busy falls.
- mode  in  2  00 pass, 01 bitwise invert, 10 bit-reverse, 11 hold (buffer only, no transmit).
- ovf_clr  in  1  clears the sticky overflow flag.
- fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky; set when a byte is dropped (OVF_DROP=1) or first refused (OVF_DROP=0).

## Operation
- RX FSM, states R_IDLE, R_ACK, R_DRAIN:
  - R_IDLE: if rx_readable and not full, push rx_data and go to R_ACK.
  - R_IDLE: if rx_readable and full:
    - OVF_DROP=1: no push, set overflow, go to R_ACK.
    - OVF_DROP=0: stay in R_IDLE and set overflow.
  - R_ACK: rx_used_tick=1 for exactly this cycle, then R_DRAIN.
  - R_DRAIN: wait for rx_readable=0, then R_IDLE. This guarantees exactly one capture per byte regardless of UART clear latency.
- TX FSM, states T_IDLE, T_WAIT_HI, T_WAIT_LO:
  - T_IDLE: if not empty, tx_busy=0 and mode!=11, pop the head, register tx_data=transform(head) using mode sampled this cycle, pulse tx_start, go to T_WAIT_HI.
  - T_WAIT_HI: wait for tx_busy=1, then T_WAIT_LO.
  - T_WAIT_LO: wait for tx_busy=0, then T_IDLE.
- Transform: invert = ~d. Reverse: bit i maps to bit DATA_W-1-i. Pass and hold leave data unchanged.
- Mode change while in T_WAIT_* does not affect the byte in flight.
- Overflow clear: ovf_clr=1 clears overflow. A set event in the same cycle wins (flag stays 1).

## Timing
- Reset values: rx_used_tick=0, tx_start=0, tx_data=0, fill=0, overflow=0. Both FSMs go to *_IDLE and FIFO pointers go to 0.
- Reset mid-byte: FIFO contents are discarded and no acknowledge is issued. A byte still pending in the UART is captured after reset release.
- Capture: rx_readable seen high in cycle N gives fill+1 and rx_used_tick=1 at N+1.
- Transmit: head available with tx_busy=0 in cycle N gives tx_start=1 and valid tx_data at N+1, and fill-1 at N+1.
- Empty-FIFO latency: rx_readable rising to tx_start is 3 cycles (push, FIFO registered, pop).
- Simultaneous push and pop: both occur and fill is unchanged.
  - When full, the push is evaluated against the pre-pop full flag, so it is refused or dropped that cycle.
  - When empty, the pushed byte is not popped that cycle.
- Pointers wrap modulo DEPTH. full is fill==DEPTH and empty is fill==0, so no pointer-equality ambiguity.

## Structure
- Shared package `uart_pkg` holds:
  - mode encodings MODE_PASS, MODE_INV, MODE_REV, MODE_HOLD;
  - RX and TX state encodings;
  - the default DATA_W.
- One sub-module: `sync_fifo` (parameters DATA_W, DEPTH). Ports: push/pop, registered head output, full, empty, count. It shares the same clk and active-low async rst.
- Transform is a combinational function inside uart_echo_buffer.

## Test plan
- Reset, then bytes 0x41, 0x42 in mode 00 with a behavioural UART model:
  - tx_data sequence is 0x41, 0x42;
  - one rx_used_tick per byte;
  - fill returns to 0.
- Mode 01 with byte 0x0F gives tx_data=0xF0. Mode 10 with byte 0x01 gives tx_data=0x80.
- Mode 11, push 16 bytes 0x00..0x0F:
  - fill=16, no tx_start;
  - switch to 00 and the same 16 bytes are transmitted in order.
- Overflow, mode 11 with FIFO full, 17th byte 0xAA:
  - OVF_DROP=1: rx_used_tick pulses, 0xAA is discarded, overflow=1;
  - OVF_DROP=0: no rx_used_tick and overflow=1 until space frees, then 0xAA is captured.
- ovf_clr asserted in the same cycle as a new overflow event: overflow stays 1. A later ovf_clr with no event clears it.
- Assert rst for 1 cycle with fill=5 and T_WAIT_LO active:
  - all outputs return to reset values;
  - the next received byte 0x55 is echoed normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART echo path: run-time transform modes,
// receive/transmit FSM states and the default byte width.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b01,
        MODE_REV  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_ACK   = 2'b01,
        R_DRAIN = 2'b10
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE    = 2'b00,
        T_WAIT_HI = 2'b01,
        T_WAIT_LO = 2'b10
    } tx_state_t;

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Byte-level handshake between the UART (master side) and the echo buffer
// (slave side): receive ready/acknowledge and transmit start/busy.
interface uart_echo_buffer_if #(
    parameter int DATA_W = uart_pkg::DATA_W_DEF
);
    logic              rx_readable;
    logic [DATA_W-1:0] rx_data;
    logic              rx_used_tick;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;

    modport master (
        output rx_readable, rx_data, tx_busy,
        input  rx_used_tick, tx_start, tx_data
    );

    modport slave (
        input  rx_readable, rx_data, tx_busy,
        output rx_used_tick, tx_start, tx_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head stage: an entry becomes poppable
// one cycle after it is counted, and the head is re-fetched after each pop.
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              head_valid,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && head_valid;

    // NOTE: storage array has no reset; occupancy is tracked by count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // Head is invalid the cycle after a pop while the next slot is fetched.
            head       <= mem[rd_ptr];
            head_valid <= (count != '0) && !do_pop;
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Receive-to-transmit bridge for the UART: buffers received bytes in a FIFO,
// applies a run-time selectable transform, and echoes them to the transmitter.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int OVF_DROP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_echo_buffer_if.slave          uart,
    input  logic [1:0]                 mode,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       overflow
);

    rx_state_t         rx_state, rx_next;
    tx_state_t         tx_state, tx_next;
    mode_t             mode_sel;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_valid;
    logic [DATA_W-1:0] head;

    function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] d,
                                                    input mode_t            m);
        logic [DATA_W-1:0] r;
        r = d;
        case (m)
            MODE_INV: r = ~d;
            MODE_REV: for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
            default:  r = d;
        endcase
        return r;
    endfunction

    assign mode_sel = mode_t'(mode);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (uart.rx_data),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fill)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= R_IDLE;
            tx_state <= T_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    // Full is the pre-pop flag, so a push coinciding with a pop on a full FIFO is refused.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rx_next           = rx_state;
        push              = 1'b0;
        ovf_set           = 1'b0;
        uart.rx_used_tick = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (uart.rx_readable) begin
                    if (!fifo_full) begin
                        push    = 1'b1;
                        rx_next = R_ACK;
                    end else begin
                        ovf_set = 1'b1;
                        if (OVF_DROP != 0) rx_next = R_ACK;
                    end
                end
            end
            R_ACK: begin
                uart.rx_used_tick = 1'b1;
                rx_next           = R_DRAIN;
            end
            R_DRAIN: if (!uart.rx_readable) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        tx_next = tx_state;
        pop     = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (head_valid && !fifo_empty && !uart.tx_busy && mode_sel != MODE_HOLD) begin
                    pop     = 1'b1;
                    tx_next = T_WAIT_HI;
                end
            end
            T_WAIT_HI: if (uart.tx_busy)  tx_next = T_WAIT_LO;
            T_WAIT_LO: if (!uart.tx_busy) tx_next = T_IDLE;
            default:   tx_next = T_IDLE;
        endcase
    end

    // tx_data only loads on a pop, so it holds through the whole transmission.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart.tx_start <= 1'b0;
            uart.tx_data  <= '0;
            overflow      <= 1'b0;
        end else begin
            uart.tx_start <= pop;
            if (pop) uart.tx_data <= transform(head, mode_sel);
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: a backpressure instance driven by a
// behavioural UART model, plus a discard-policy instance for the drop case.
module tb_uart_echo_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_echo_buffer_if #(.DATA_W(8)) bus  ();
    uart_echo_buffer_if #(.DATA_W(8)) bus2 ();

    logic [1:0] mode, mode2;
    logic       ovf_clr, ovf_clr2;
    logic [4:0] fill, fill2;
    logic       overflow, overflow2;

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .OVF_DROP(0)) dut (
        .clk(clk), .rst(rst), .uart(bus), .mode(mode), .ovf_clr(ovf_clr),
        .fill(fill), .overflow(overflow)
    );

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .OVF_DROP(1)) dut_drop (
        .clk(clk), .rst(rst), .uart(bus2), .mode(mode2), .ovf_clr(ovf_clr2),
        .fill(fill2), .overflow(overflow2)
    );

    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         ack_cnt  = 0;
    int         ack_cnt2 = 0;
    int         busy_len = 3;
    logic [7:0] txq  [$];
    logic [7:0] txq2 [$];

    // Monitors: record every transmitted byte and every acknowledge.
    always @(negedge clk) begin
        if (bus.tx_start)      txq.push_back(bus.tx_data);
        if (bus.rx_used_tick)  ack_cnt++;
        if (bus2.tx_start)     txq2.push_back(bus2.tx_data);
        if (bus2.rx_used_tick) ack_cnt2++;
    end

    // Transmitter models: busy rises the cycle after tx_start.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                bus.tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        bus2.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.tx_start) begin
                bus2.tx_busy = 1'b1;
                @(negedge clk);
                bus2.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        @(negedge clk);
        bus.rx_readable = 1'b1;
        bus.rx_data     = b;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.rx_used_tick) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL send_ack byte=%02h: got no rx_used_tick, required one", b);
        end
        @(negedge clk);
        bus.rx_readable = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        bit got = 1'b0;
        @(negedge clk);
        bus2.rx_readable = 1'b1;
        bus2.rx_data     = b;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus2.rx_used_tick) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL send2_ack byte=%02h: got no rx_used_tick, required one", b);
        end
        @(negedge clk);
        bus2.rx_readable = 1'b0;
    endtask

    task automatic wait_start(input int n, input string tag);
        int k = 0;
        while (txq.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (txq.size() < n) begin
            n_bad++;
            $display("FAIL %s: %0d bytes transmitted, required %0d", tag, txq.size(), n);
        end
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        @(negedge clk);
        while (bus.tx_busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: tx_busy=%b, required 0", tag, bus.tx_busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.rx_used_tick !== 1'b0) begin n_bad++; $display("FAIL reset_rx_used_tick: got %b want 0", bus.rx_used_tick); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %02h want 00", bus.tx_data); end
        n_cmp++; if (fill !== 5'd0) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (fill2 !== 5'd0 || overflow2 !== 1'b0) begin n_bad++; $display("FAIL reset_drop_dut: fill=%0d ovf=%b want 0/0", fill2, overflow2); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pass();
        int ack0 = ack_cnt;
        int base = txq.size();
        mode = 2'b00;
        // Cycle-accurate first byte: ack at +1, tx_start at +3.
        @(negedge clk);
        bus.rx_readable = 1'b1;
        bus.rx_data     = 8'h41;
        @(negedge clk);
        n_cmp++; if (bus.rx_used_tick !== 1'b1) begin n_bad++; $display("FAIL capture_tick: got %b want 1", bus.rx_used_tick); end
        n_cmp++; if (fill !== 5'd1) begin n_bad++; $display("FAIL capture_fill: got %0d want 1", fill); end
        bus.rx_readable = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL early_tx_start: got %b want 0", bus.tx_start); end
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b1) begin n_bad++; $display("FAIL latency_tx_start: got %b want 1", bus.tx_start); end
        n_cmp++; if (bus.tx_data !== 8'h41) begin n_bad++; $display("FAIL latency_tx_data: got %02h want 41", bus.tx_data); end
        n_cmp++; if (fill !== 5'd0) begin n_bad++; $display("FAIL pop_fill: got %0d want 0", fill); end
        wait_quiet("pass_first");
        send_byte(8'h42);
        wait_start(base + 2, "pass_second");
        wait_quiet("pass_second");
        n_cmp++; if (txq.size() < base + 2 || txq[base] !== 8'h41 || txq[base+1] !== 8'h42) begin
            n_bad++; $display("FAIL pass_sequence: got %0d bytes, required 41 42", txq.size() - base);
        end
        n_cmp++; if (ack_cnt - ack0 !== 2) begin n_bad++; $display("FAIL pass_acks: got %0d want 2", ack_cnt - ack0); end
        n_cmp++; if (fill !== 5'd0) begin n_bad++; $display("FAIL pass_fill: got %0d want 0", fill); end
    endtask

    task automatic test_transform();
        logic [1:0] tm [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        logic [7:0] ti [4] = '{8'h0F, 8'h01, 8'hC2, 8'hA5};
        logic [7:0] te [4] = '{8'hF0, 8'h80, 8'h43, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            int base = txq.size();
            mode = tm[i];
            send_byte(ti[i]);
            wait_start(base + 1, "xform_start");
            mode = 2'b00;  // change while the byte is in flight
            repeat (2) @(negedge clk);
            n_cmp++; if (bus.tx_data !== te[i]) begin n_bad++; $display("FAIL xform_inflight[%0d]: got %02h want %02h", i, bus.tx_data, te[i]); end
            wait_quiet("xform");
            n_cmp++; if (txq.size() <= base || txq[base] !== te[i]) begin n_bad++; $display("FAIL xform_data[%0d]: want %02h", i, te[i]); end
        end
    endtask

    task automatic test_hold();
        int base = txq.size();
        mode = 2'b11;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        repeat (4) @(negedge clk);
        n_cmp++; if (fill !== 5'd16) begin n_bad++; $display("FAIL hold_fill: got %0d want 16", fill); end
        n_cmp++; if (txq.size() != base) begin n_bad++; $display("FAIL hold_no_tx: got %0d starts want 0", txq.size() - base); end
        mode = 2'b00;
        wait_start(base + 16, "hold_drain");
        wait_quiet("hold_drain");
        for (int i = 0; i < 16; i++) begin
            logic [7:0] got = (base + i < txq.size()) ? txq[base+i] : 8'hxx;
            n_cmp++; if (got !== 8'(i)) begin n_bad++; $display("FAIL hold_order[%0d]: got %02h want %02h", i, got, 8'(i)); end
        end
        n_cmp++; if (fill !== 5'd0) begin n_bad++; $display("FAIL hold_fill_end: got %0d want 0", fill); end
    endtask

    task automatic test_overflow_backpressure();
        int  base = txq.size();
        int  ack0;
        bit  got = 1'b0;
        mode = 2'b11;
        for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h20));
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_ovf_before: got %b want 0", overflow); end
        ack0 = ack_cnt;
        bus.rx_readable = 1'b1;
        bus.rx_data     = 8'hAA;
        repeat (4) @(negedge clk);
        n_cmp++; if (ack_cnt != ack0) begin n_bad++; $display("FAIL bp_no_ack: got %0d acks want 0", ack_cnt - ack0); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
        n_cmp++; if (fill !== 5'd16) begin n_bad++; $display("FAIL bp_fill: got %0d want 16", fill); end
        ovf_clr = 1'b1;  // coincides with a continuing refusal
        @(negedge clk);
        ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_clr_vs_set: got %b want 1", overflow); end
        mode = 2'b00;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.rx_used_tick) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL bp_late_capture: got no ack, required one"); end
        @(negedge clk);
        bus.rx_readable = 1'b0;
        wait_start(base + 17, "bp_drain");
        wait_quiet("bp_drain");
        n_cmp++; if (txq.size() < base + 17 || txq[base+16] !== 8'hAA) begin n_bad++; $display("FAIL bp_last_byte: required AA as byte 17"); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_sticky: got %b want 1", overflow); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_clear: got %b want 0", overflow); end
    endtask

    task automatic test_overflow_drop();
        int k = 0;
        mode2 = 2'b11;
        for (int i = 0; i < 16; i++) send2(8'(i));
        @(negedge clk);
        n_cmp++; if (fill2 !== 5'd16 || overflow2 !== 1'b0) begin n_bad++; $display("FAIL drop_full: fill=%0d ovf=%b want 16/0", fill2, overflow2); end
        send2(8'hAA);
        n_cmp++; if (overflow2 !== 1'b1) begin n_bad++; $display("FAIL drop_ovf: got %b want 1", overflow2); end
        n_cmp++; if (fill2 !== 5'd16) begin n_bad++; $display("FAIL drop_fill: got %0d want 16", fill2); end
        n_cmp++; if (ack_cnt2 != 17) begin n_bad++; $display("FAIL drop_acks: got %0d want 17", ack_cnt2); end
        mode2 = 2'b00;
        while (txq2.size() < 16 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        n_cmp++; if (txq2.size() != 16) begin n_bad++; $display("FAIL drop_count: got %0d bytes want 16", txq2.size()); end
        n_cmp++; if (txq2.size() < 16 || txq2[15] !== 8'h0F) begin n_bad++; $display("FAIL drop_last: required 0F as final byte"); end
        n_cmp++; if (fill2 !== 5'd0) begin n_bad++; $display("FAIL drop_fill_end: got %0d want 0", fill2); end
    endtask

    task automatic test_reset_mid_byte();
        int base = txq.size();
        bit got  = 1'b0;
        busy_len = 60;
        mode     = 2'b00;
        send_byte(8'h11);
        wait_start(base + 1, "rm_first");
        mode = 2'b11;
        for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h60));
        @(negedge clk);
        n_cmp++; if (fill !== 5'd5) begin n_bad++; $display("FAIL rm_fill_before: got %0d want 5", fill); end
        n_cmp++; if (bus.tx_busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_before: got %b want 1", bus.tx_busy); end
        rst             = 1'b0;
        mode            = 2'b00;
        bus.rx_readable = 1'b1;
        bus.rx_data     = 8'h55;
        #1;
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL rm_tx_start: got %b want 0", bus.tx_start); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL rm_tx_data: got %02h want 00", bus.tx_data); end
        n_cmp++; if (fill !== 5'd0) begin n_bad++; $display("FAIL rm_fill: got %0d want 0", fill); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rm_overflow: got %b want 0", overflow); end
        @(negedge clk);
        n_cmp++; if (bus.rx_used_tick !== 1'b0) begin n_bad++; $display("FAIL rm_no_ack: got %b want 0", bus.rx_used_tick); end
        rst      = 1'b1;
        busy_len = 3;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.rx_used_tick) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rm_capture: got no ack, required one"); end
        @(negedge clk);
        bus.rx_readable = 1'b0;
        wait_start(base + 2, "rm_echo");
        wait_quiet("rm_echo");
        repeat (10) @(negedge clk);
        n_cmp++; if (txq.size() < base + 2 || txq[base+1] !== 8'h55) begin n_bad++; $display("FAIL rm_echo_data: required 55 after reset"); end
        n_cmp++; if (txq.size() != base + 2) begin n_bad++; $display("FAIL rm_discard: got %0d bytes want 2", txq.size() - base); end
        n_cmp++; if (fill !== 5'd0) begin n_bad++; $display("FAIL rm_fill_end: got %0d want 0", fill); end
    endtask

    initial begin
        bus.rx_readable  = 1'b0;
        bus.rx_data      = 8'h00;
        bus2.rx_readable = 1'b0;
        bus2.rx_data     = 8'h00;
        mode             = 2'b00;
        mode2            = 2'b11;
        ovf_clr          = 1'b0;
        ovf_clr2         = 1'b0;
        test_reset();
        test_pass();
        test_transform();
        test_hold();
        test_overflow_backpressure();
        test_overflow_drop();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
